// File: rtl/alu_operand_if.sv
// Decode/forwarding/execute bundle for the ALU operand stage.
// The master side is the surrounding pipeline; the slave side is alu_operand_stage.
interface alu_operand_if #(
    parameter int DATA_W    = 32,
    parameter int SHAMT_W   = 5,
    parameter int REG_IDX_W = 5
);
    logic                 in_valid;
    logic                 in_ready;
    logic [REG_IDX_W-1:0] rs_idx;
    logic [REG_IDX_W-1:0] rt_idx;
    logic [DATA_W-1:0]    rs_data;
    logic [DATA_W-1:0]    rt_data;
    logic [DATA_W-1:0]    ext_imm;
    logic [SHAMT_W-1:0]   shamt;
    logic [1:0]           alu_src;
    logic                 exmem_wen;
    logic                 memwb_wen;
    logic [REG_IDX_W-1:0] exmem_rd;
    logic [REG_IDX_W-1:0] memwb_rd;
    logic [DATA_W-1:0]    exmem_data;
    logic [DATA_W-1:0]    memwb_data;
    logic                 exmem_is_load;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [DATA_W-1:0]    op_a;
    logic [DATA_W-1:0]    op_b;

    modport master (
        output in_valid, rs_idx, rt_idx, rs_data, rt_data, ext_imm, shamt, alu_src,
               exmem_wen, memwb_wen, exmem_rd, memwb_rd, exmem_data, memwb_data,
               exmem_is_load, flush, out_ready,
        input  in_ready, out_valid, op_a, op_b
    );

    modport slave (
        input  in_valid, rs_idx, rt_idx, rs_data, rt_data, ext_imm, shamt, alu_src,
               exmem_wen, memwb_wen, exmem_rd, memwb_rd, exmem_data, memwb_data,
               exmem_is_load, flush, out_ready,
        output in_ready, out_valid, op_a, op_b
    );
endinterface

// File: rtl/alu_operand_stage.sv
// Registered ALU operand stage: forwarding, load-use hazard hold, one-deep valid/ready register.
// Optional load-use stall counter enabled by defining ALU_OPERAND_STATS_EN.
module alu_operand_stage #(
    parameter int DATA_W    = 32,
    parameter int SHAMT_W   = 5,
    parameter int REG_IDX_W = 5
) (
    input  logic CLK,
    input  logic RST,
    alu_operand_if.slave bus
`ifdef ALU_OPERAND_STATS_EN
    ,
    output logic [15:0] stall_count
`endif
);
    localparam int HALF_W = DATA_W / 2;

    // EX/MEM beats MEM/WB; a load in EX/MEM has no data yet, so it never forwards.
    function automatic logic [DATA_W-1:0] fwd(
        input logic [REG_IDX_W-1:0] idx,
        input logic [DATA_W-1:0]    regval,
        input logic                 em_wen,
        input logic [REG_IDX_W-1:0] em_rd,
        input logic [DATA_W-1:0]    em_data,
        input logic                 em_load,
        input logic                 mw_wen,
        input logic [REG_IDX_W-1:0] mw_rd,
        input logic [DATA_W-1:0]    mw_data
    );
        if (idx == '0)
            return regval;
        if (em_wen && em_rd == idx && !em_load)
            return em_data;
        if (mw_wen && mw_rd == idx)
            return mw_data;
        return regval;
    endfunction

    logic              w_hazard;
    logic              w_in_ready;
    logic              w_accept;
    logic [DATA_W-1:0] w_op_a;
    logic [DATA_W-1:0] w_op_b;
    logic [DATA_W-1:0] w_fwd_b;

    logic              r_vld_p0;
    logic [DATA_W-1:0] r_op_a_p0;
    logic [DATA_W-1:0] r_op_b_p0;

    assign w_hazard = bus.in_valid && bus.exmem_wen && bus.exmem_is_load &&
                      (bus.exmem_rd != '0) &&
                      ((bus.exmem_rd == bus.rs_idx) ||
                       (bus.alu_src == 2'd0 && bus.exmem_rd == bus.rt_idx));

    assign w_in_ready = !RST && (!r_vld_p0 || bus.out_ready) && !w_hazard && !bus.flush;
    assign w_accept   = bus.in_valid && w_in_ready;

    assign w_op_a  = fwd(bus.rs_idx, bus.rs_data, bus.exmem_wen, bus.exmem_rd, bus.exmem_data,
                         bus.exmem_is_load, bus.memwb_wen, bus.memwb_rd, bus.memwb_data);
    assign w_fwd_b = fwd(bus.rt_idx, bus.rt_data, bus.exmem_wen, bus.exmem_rd, bus.exmem_data,
                         bus.exmem_is_load, bus.memwb_wen, bus.memwb_rd, bus.memwb_data);

    always_comb begin
        w_op_b = w_fwd_b;
        case (bus.alu_src)
            2'd0:    w_op_b = w_fwd_b;
            2'd1:    w_op_b = bus.ext_imm;
            2'd2:    w_op_b = {{(DATA_W-SHAMT_W){1'b0}}, bus.shamt};
            default: w_op_b = {bus.ext_imm[HALF_W-1:0], {HALF_W{1'b0}}};
        endcase
    end

    // Stage p0: operand register; held values stay frozen while execute stalls.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_vld_p0  <= 1'b0;
            r_op_a_p0 <= '0;
            r_op_b_p0 <= '0;
        end else if (bus.flush) begin
            r_vld_p0 <= 1'b0;
        end else if (w_accept) begin
            r_vld_p0  <= 1'b1;
            r_op_a_p0 <= w_op_a;
            r_op_b_p0 <= w_op_b;
        end else if (bus.out_ready) begin
            r_vld_p0 <= 1'b0;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_vld_p0;
    assign bus.op_a      = r_op_a_p0;
    assign bus.op_b      = r_op_b_p0;

`ifdef ALU_OPERAND_STATS_EN
    logic [15:0] r_stall_cnt_p0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_stall_cnt_p0 <= '0;
        else if (w_hazard && !bus.flush && r_stall_cnt_p0 != 16'hFFFF)
            r_stall_cnt_p0 <= r_stall_cnt_p0 + 16'd1;
    end

    assign stall_count = r_stall_cnt_p0;
`endif
endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Registered ALU operand stage for the pipelined core, sitting between decode and execute. It selects operand A and operand B, resolving RAW hazards by forwarding from EX/MEM and MEM/WB, and detects load-use hazards, holding decode back while they persist. Selected operands are captured into a one-deep valid/ready pipeline register. It is the parametrised successor of the combinational operand-B mux, adding forwarding, an upper-immediate mode, stall/flush control and an optional stall counter.

## Interface
- DATA_W, 32: datapath width in bits; must be even and ≥ SHAMT_W.
- SHAMT_W, 5: shift-amount field width.
- REG_IDX_W, 5: register index width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, asynchronous and active-high.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage accepts this cycle.
- rs_idx, rt_idx  in  REG_IDX_W  source register indices.
- rs_data, rt_data  in  DATA_W  register-file read values.
- ext_imm  in  DATA_W  sign/zero-extended immediate.
- shamt  in  SHAMT_W  shift-amount field.
- alu_src  in  2  operand-B select: 0 = reg, 1 = imm, 2 = shamt, 3 = upper imm.
- exmem_wen, memwb_wen  in  1  downstream writeback enables.
- exmem_rd, memwb_rd  in  REG_IDX_W  downstream destination indices.
- exmem_data, memwb_data  in  DATA_W  downstream result values.
- exmem_is_load  in  1  EX/MEM instruction is a load (data not yet available).
- flush  in  1  discard the held and incoming instruction.
- out_valid  out  1  op_a/op_b valid to execute.
- out_ready  in  1  execute consumes.
- op_a, op_b  out  DATA_W  registered operands.
- stall_count  out  16  load-use stall cycles (only with ALU_OPERAND_STATS_EN).

## Operation
- Forwarded value fwd(idx, regval), priority order:
  - exmem_wen && exmem_rd==idx && idx!=0 && !exmem_is_load → exmem_data.
  - else memwb_wen && memwb_rd==idx && idx!=0 → memwb_data.
  - else regval.
  - Index 0 is never forwarded.
- A = fwd(rs_idx, rs_data).
- B by alu_src:
  - 0 → fwd(rt_idx, rt_data).
  - 1 → ext_imm.
  - 2 → shamt zero-extended to DATA_W.
  - 3 → {ext_imm[DATA_W/2-1:0], DATA_W/2 zeros}.
- hazard = in_valid && exmem_wen && exmem_is_load && exmem_rd!=0 && (exmem_rd==rs_idx || (alu_src==0 && exmem_rd==rt_idx)).
- in_ready = (!out_valid || out_ready) && !hazard && !flush.
- Accept = in_valid && in_ready: op_a/op_b are loaded and out_valid is set.
- Consume without accept: out_valid is cleared; op_a/op_b retain their last values.
- Held (out_valid && !out_ready): op_a/op_b are frozen and the held values are not re-forwarded.
- flush: out_valid is cleared next edge and no accept occurs that cycle, regardless of out_ready or in_valid.

## Timing
- Reset (async assert, applies immediately): out_valid=0, op_a=0, op_b=0, stall_count=0.
- in_ready=0 while RST is high.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 per cycle while out_ready is high and there is no hazard.
- Hazard is combinational and lasts while the EX/MEM load matches. It is typically 1 cycle; it clears when the load advances to MEM/WB, and the value is then forwarded from memwb_data.
- EX/MEM and MEM/WB match the same index: EX/MEM wins unless it is a load (hazard).
- Accept and consume in the same cycle: the new operands replace the old, and out_valid stays 1.
- flush during hazard: no stall is counted for that cycle.
- in_valid low while ready: out_valid falls after consume, with no bubble insertion beyond that.

## Configuration
- ALU_OPERAND_STATS_EN defined:
  - stall_count increments each cycle hazard && !flush, saturating at 16'hFFFF.
  - Reset to 0 by RST.
- Not defined: stall_count port and counter are absent; behaviour is otherwise identical.

## Test plan
- Plain register operands: rs_idx=3, rs_data=10, rt_idx=4, rt_data=20, alu_src=0, no wen → next cycle out_valid=1, op_a=10, op_b=20.
- Forward priority: exmem_rd=3 wen data=0xAAAA and memwb_rd=3 wen data=0xBBBB, rs_idx=3 → op_a=0xAAAA. With exmem_wen=0 → op_a=0xBBBB. With rs_idx=0 → op_a=rs_data.
- Load-use: exmem_is_load=1, exmem_rd=rt_idx=5, alu_src=0 → in_ready=0 for 1 cycle and stall_count 0→1. Next cycle memwb_rd=5, memwb_data=0x1234 → op_b=0x1234. Same with alu_src=1 → no stall.
- Modes: ext_imm=0x0000ABCD: alu_src=1 → op_b=0x0000ABCD; alu_src=3 → 0xABCD0000; shamt=31, alu_src=2 → 0x0000001F.
- Backpressure/flush: out_ready=0 for 3 cycles → op_a/op_b stable and in_ready=0. Assert flush with in_valid=1 → out_valid=0 next cycle and the instruction is not captured.
- Reset mid-stream: assert RST while out_valid=1 and stall_count=7 → out_valid, op_a, op_b and stall_count read 0 before the next CLK edge.
